// File: rtl/ev_pop_streamer.sv
// Host-side population feeder and result collector for the evolutionary-algorithm core.
// Streams a host-written population as one gap-free burst, then waits (with watchdog) for the core's results.
module ev_pop_streamer #(
    parameter int INT8_LENGTH     = 8,
    parameter int PARTICLE_LENGTH = 2,
    parameter int LATTICE_LENGTH  = 11,
    parameter int IND_FIT_LENGTH  = 10,
    parameter int MAX_POP         = 32,
    parameter int ADDR_W          = 5,
    parameter int TIMEOUT         = 1000
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      wr_en,
    input  logic [ADDR_W-1:0]                         wr_addr,
    input  logic [PARTICLE_LENGTH*LATTICE_LENGTH-1:0] wr_state,
    input  logic [INT8_LENGTH-1:0]                    wr_mut,
    input  logic                                      start,
    input  logic [INT8_LENGTH-1:0]                    pop_size_cfg,
    output logic                                      busy,
    output logic                                      cfg_err,
    output logic                                      timeout,
    output logic                                      in_valid,
    output logic [PARTICLE_LENGTH*LATTICE_LENGTH-1:0] ind_state_out,
    output logic [INT8_LENGTH-1:0]                    Mutate_rate_out,
    input  logic                                      done_in,
    input  logic [IND_FIT_LENGTH-1:0]                 Min_fit_in,
    input  logic [PARTICLE_LENGTH*LATTICE_LENGTH-1:0] Best_ind_state_in,
    input  logic [INT8_LENGTH-1:0]                    Best_ind_mut_in,
    output logic                                      result_valid,
    output logic [IND_FIT_LENGTH-1:0]                 min_fit,
    output logic [PARTICLE_LENGTH*LATTICE_LENGTH-1:0] best_state,
    output logic [INT8_LENGTH-1:0]                    best_mut
);
    // state   | meaning
    // S_IDLE  | host may write the buffer; waits for start
    // S_STREAM| driving buf[0..pop-1] with in_valid high, one per cycle
    // S_WAIT  | burst sent; waiting for done_in or watchdog expiry

    localparam int SW    = PARTICLE_LENGTH * LATTICE_LENGTH;
    localparam int IDX_W = ADDR_W + 1;
    localparam int CNT_W = 16;
    localparam logic [INT8_LENGTH-1:0] MAX_POP_W = INT8_LENGTH'(MAX_POP);
    localparam logic [CNT_W-1:0]       TO_LAST   = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [IDX_W-1:0]         pop_q, pop_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     in_valid_q, in_valid_d;
    logic [SW-1:0]            st_out_q, st_out_d;
    logic [INT8_LENGTH-1:0]   mut_out_q, mut_out_d;
    logic                     cfg_err_q, cfg_err_d;
    logic                     timeout_q, timeout_d;
    logic                     rv_q, rv_d;
    logic [IND_FIT_LENGTH-1:0] min_fit_q, min_fit_d;
    logic [SW-1:0]            best_state_q, best_state_d;
    logic [INT8_LENGTH-1:0]   best_mut_q, best_mut_d;

    logic [SW-1:0]            buf_state_q [MAX_POP];
    logic [INT8_LENGTH-1:0]   buf_mut_q   [MAX_POP];
    logic                     buf_we;
    logic                     size_ok;
    logic [ADDR_W-1:0]        rd_addr;

    assign size_ok = (pop_size_cfg != '0) && (pop_size_cfg <= MAX_POP_W);
    assign rd_addr = idx_q[ADDR_W-1:0];

    // Storage is never reset; reads in the same cycle as a write see the old word.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_state_q[wr_addr] <= wr_state;
            buf_mut_q[wr_addr]   <= wr_mut;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            pop_q        <= '0;
            cnt_q        <= '0;
            in_valid_q   <= 1'b0;
            st_out_q     <= '0;
            mut_out_q    <= '0;
            cfg_err_q    <= 1'b0;
            timeout_q    <= 1'b0;
            rv_q         <= 1'b0;
            min_fit_q    <= '0;
            best_state_q <= '0;
            best_mut_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pop_q        <= pop_d;
            cnt_q        <= cnt_d;
            in_valid_q   <= in_valid_d;
            st_out_q     <= st_out_d;
            mut_out_q    <= mut_out_d;
            cfg_err_q    <= cfg_err_d;
            timeout_q    <= timeout_d;
            rv_q         <= rv_d;
            min_fit_q    <= min_fit_d;
            best_state_q <= best_state_d;
            best_mut_q   <= best_mut_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pop_d        = pop_q;
        cnt_d        = cnt_q;
        in_valid_d   = in_valid_q;
        st_out_d     = st_out_q;
        mut_out_d    = mut_out_q;
        cfg_err_d    = cfg_err_q;
        timeout_d    = timeout_q;
        rv_d         = rv_q;
        min_fit_d    = min_fit_q;
        best_state_d = best_state_q;
        best_mut_d   = best_mut_q;
        buf_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                buf_we = wr_en;
                if (start) begin
                    if (size_ok) begin
                        pop_d      = pop_size_cfg[IDX_W-1:0];
                        rv_d       = 1'b0;
                        timeout_d  = 1'b0;
                        cfg_err_d  = 1'b0;
                        st_out_d   = buf_state_q[0];
                        mut_out_d  = buf_mut_q[0];
                        in_valid_d = 1'b1;
                        idx_d      = IDX_W'(1);
                        state_d    = S_STREAM;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_STREAM: begin
                if (idx_q < pop_q) begin
                    st_out_d  = buf_state_q[rd_addr];
                    mut_out_d = buf_mut_q[rd_addr];
                    idx_d     = idx_q + 1'b1;
                end else begin
                    in_valid_d = 1'b0;
                    st_out_d   = '0;
                    mut_out_d  = '0;
                    cnt_d      = '0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                // done takes priority over the watchdog on the same edge
                if (done_in) begin
                    min_fit_d    = Min_fit_in;
                    best_state_d = Best_ind_state_in;
                    best_mut_d   = Best_ind_mut_in;
                    rv_d         = 1'b1;
                    state_d      = S_IDLE;
                end else if (cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy            = (state_q == S_STREAM) || (state_q == S_WAIT);
    assign cfg_err         = cfg_err_q;
    assign timeout         = timeout_q;
    assign in_valid        = in_valid_q;
    assign ind_state_out   = st_out_q;
    assign Mutate_rate_out = mut_out_q;
    assign result_valid    = rv_q;
    assign min_fit         = min_fit_q;
    assign best_state      = best_state_q;
    assign best_mut        = best_mut_q;

endmodule

// File: tb/tb_ev_pop_streamer.sv
// Directed bench for ev_pop_streamer: stream burst shape, result capture, size rejection,
// watchdog boundary, ignored inputs while busy, async reset and read-before-write.
module tb_ev_pop_streamer;
    localparam int TIMEOUT = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [21:0] wr_state;
    logic [7:0]  wr_mut;
    logic        start;
    logic [7:0]  pop_size_cfg;
    logic        busy, cfg_err, timeout, in_valid;
    logic [21:0] ind_state_out;
    logic [7:0]  Mutate_rate_out;
    logic        done_in;
    logic [9:0]  Min_fit_in;
    logic [21:0] Best_ind_state_in;
    logic [7:0]  Best_ind_mut_in;
    logic        result_valid;
    logic [9:0]  min_fit;
    logic [21:0] best_state;
    logic [7:0]  best_mut;

    int n_checks = 0;
    int n_errors = 0;

    ev_pop_streamer #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_state(wr_state), .wr_mut(wr_mut),
        .start(start), .pop_size_cfg(pop_size_cfg),
        .busy(busy), .cfg_err(cfg_err), .timeout(timeout),
        .in_valid(in_valid), .ind_state_out(ind_state_out), .Mutate_rate_out(Mutate_rate_out),
        .done_in(done_in), .Min_fit_in(Min_fit_in),
        .Best_ind_state_in(Best_ind_state_in), .Best_ind_mut_in(Best_ind_mut_in),
        .result_valid(result_valid), .min_fit(min_fit),
        .best_state(best_state), .best_mut(best_mut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stream(input string tag, input logic v, input logic [21:0] s, input logic [7:0] m);
        chk({tag, "_valid"}, {31'd0, in_valid}, {31'd0, v});
        chk({tag, "_state"}, {10'd0, ind_state_out}, {10'd0, s});
        chk({tag, "_mut"}, {24'd0, Mutate_rate_out}, {24'd0, m});
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 0; wr_addr = '0; wr_state = '0; wr_mut = '0;
        start = 0; pop_size_cfg = '0; done_in = 0; Min_fit_in = '0;
        Best_ind_state_in = '0; Best_ind_mut_in = '0;
        #22;
        chk_stream("rst", 1'b0, 22'd0, 8'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        chk("rst_rv", {31'd0, result_valid}, 32'd0);
        chk("rst_min_fit", {22'd0, min_fit}, 32'd0);
        rst_n = 1'b1;
        step();

        // Load 4 individuals: state = addr*3, mut = addr+10
        for (int i = 0; i < 4; i++) begin
            wr_en = 1; wr_addr = 5'(i); wr_state = 22'(i * 3); wr_mut = 8'(i + 10);
            step();
        end
        wr_en = 0;

        start = 1; pop_size_cfg = 8'd4;
        #1;
        chk("pre_start_valid", {31'd0, in_valid}, 32'd0);
        step();
        start = 0;
        chk_stream("s4_0", 1'b1, 22'd0, 8'd10);
        chk("s4_busy", {31'd0, busy}, 32'd1);
        for (int i = 1; i < 4; i++) begin
            step();
            chk_stream("s4_i", 1'b1, 22'(i * 3), 8'(i + 10));
        end
        step();
        chk_stream("s4_end", 1'b0, 22'd0, 8'd0);
        chk("wait_busy", {31'd0, busy}, 32'd1);
        step(); step();
        chk("wait_busy2", {31'd0, busy}, 32'd1);

        done_in = 1; Min_fit_in = 10'd37; Best_ind_state_in = 22'h15A5A; Best_ind_mut_in = 8'd9;
        step();
        done_in = 0; Min_fit_in = '0; Best_ind_state_in = '0; Best_ind_mut_in = '0;
        chk("cap_rv", {31'd0, result_valid}, 32'd1);
        chk("cap_min", {22'd0, min_fit}, 32'd37);
        chk("cap_state", {10'd0, best_state}, 32'h15A5A);
        chk("cap_mut", {24'd0, best_mut}, 32'd9);
        chk("cap_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_rv", {31'd0, result_valid}, 32'd1);
        end
        chk("hold_min", {22'd0, min_fit}, 32'd37);
        chk("hold_state", {10'd0, best_state}, 32'h15A5A);
        chk("hold_mut", {24'd0, best_mut}, 32'd9);

        // Invalid sizes
        start = 1; pop_size_cfg = 8'd0;
        step();
        start = 0;
        chk("cfg0_err", {31'd0, cfg_err}, 32'd1);
        chk("cfg0_valid", {31'd0, in_valid}, 32'd0);
        chk("cfg0_busy", {31'd0, busy}, 32'd0);
        step();
        start = 1; pop_size_cfg = 8'd33;
        step();
        start = 0;
        chk("cfg33_err", {31'd0, cfg_err}, 32'd1);
        chk("cfg33_busy", {31'd0, busy}, 32'd0);
        step();
        chk("cfg33_valid", {31'd0, in_valid}, 32'd0);
        chk("cfg_rv_kept", {31'd0, result_valid}, 32'd1);
        chk("cfg_min_kept", {22'd0, min_fit}, 32'd37);

        // Watchdog: no done
        start = 1; pop_size_cfg = 8'd2;
        step();
        start = 0;
        chk("to_cfg_clr", {31'd0, cfg_err}, 32'd0);
        chk("to_rv_clr", {31'd0, result_valid}, 32'd0);
        step();
        chk_stream("to_s1", 1'b1, 22'd3, 8'd11);
        step();
        chk("to_entry_valid", {31'd0, in_valid}, 32'd0);
        for (int i = 1; i < TIMEOUT; i++) step();
        chk("to_pre_timeout", {31'd0, timeout}, 32'd0);
        chk("to_pre_busy", {31'd0, busy}, 32'd1);
        step();
        chk("to_timeout", {31'd0, timeout}, 32'd1);
        chk("to_busy", {31'd0, busy}, 32'd0);
        chk("to_rv", {31'd0, result_valid}, 32'd0);
        step();
        chk("to_sticky", {31'd0, timeout}, 32'd1);

        // Watchdog: done on the final count wins
        start = 1; pop_size_cfg = 8'd2;
        step();
        start = 0;
        chk("to2_clr", {31'd0, timeout}, 32'd0);
        step(); step();
        for (int i = 1; i < TIMEOUT; i++) step();
        done_in = 1; Min_fit_in = 10'd5; Best_ind_state_in = 22'h3FFFF; Best_ind_mut_in = 8'd200;
        step();
        done_in = 0;
        chk("last_timeout", {31'd0, timeout}, 32'd0);
        chk("last_rv", {31'd0, result_valid}, 32'd1);
        chk("last_min", {22'd0, min_fit}, 32'd5);
        chk("last_state", {10'd0, best_state}, 32'h3FFFF);
        chk("last_mut", {24'd0, best_mut}, 32'd200);
        chk("last_busy", {31'd0, busy}, 32'd0);

        // Inputs ignored while streaming
        start = 1; pop_size_cfg = 8'd4;
        step();
        start = 0;
        wr_en = 1; wr_addr = 5'd1; wr_state = 22'h3FFFF; wr_mut = 8'hFF;
        start = 1; pop_size_cfg = 8'd1;
        done_in = 1; Min_fit_in = 10'd99;
        step();
        wr_en = 0; start = 0; done_in = 0; Min_fit_in = '0;
        chk_stream("ign_1", 1'b1, 22'd3, 8'd11);
        step();
        chk_stream("ign_2", 1'b1, 22'd6, 8'd12);
        step();
        chk_stream("ign_3", 1'b1, 22'd9, 8'd13);
        step();
        chk_stream("ign_end", 1'b0, 22'd0, 8'd0);
        chk("ign_busy", {31'd0, busy}, 32'd1);
        chk("ign_rv", {31'd0, result_valid}, 32'd0);
        done_in = 1; Min_fit_in = 10'd100; Best_ind_state_in = 22'h00123; Best_ind_mut_in = 8'd7;
        step();
        done_in = 0;
        chk("ign_cap_min", {22'd0, min_fit}, 32'd100);

        // Asynchronous reset mid-burst
        start = 1; pop_size_cfg = 8'd4;
        step();
        start = 0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk_stream("arst", 1'b0, 22'd0, 8'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_rv", {31'd0, result_valid}, 32'd0);
        chk("arst_min", {22'd0, min_fit}, 32'd0);
        #3;
        rst_n = 1'b1;
        step();
        start = 1; pop_size_cfg = 8'd3;
        step();
        start = 0;
        chk_stream("re_0", 1'b1, 22'd0, 8'd10);
        step();
        chk_stream("re_1", 1'b1, 22'd3, 8'd11);
        step();
        chk_stream("re_2", 1'b1, 22'd6, 8'd12);
        step();
        chk_stream("re_end", 1'b0, 22'd0, 8'd0);
        done_in = 1;
        step();
        done_in = 0;

        // Write and start in the same cycle: stream sees the pre-write word
        wr_en = 1; wr_addr = 5'd0; wr_state = 22'h2AAAA; wr_mut = 8'h55;
        start = 1; pop_size_cfg = 8'd1;
        step();
        wr_en = 0; start = 0;
        chk_stream("rbw_old", 1'b1, 22'd0, 8'd10);
        step();
        chk_stream("rbw_end", 1'b0, 22'd0, 8'd0);
        done_in = 1;
        step();
        done_in = 0;
        start = 1; pop_size_cfg = 8'd1;
        step();
        start = 0;
        chk_stream("rbw_new", 1'b1, 22'h2AAAA, 8'h55);
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
